fifo_push_arbiter: RTL
======================

Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares the single push port of the two-clock FIFO among N_REQ producers in the clk_push domain.
- Grants one requester at a time for a burst of up to BURST_LEN accepted words.
- Generates the FIFO push strobe and data from the granted requester, honouring full_out backpressure.
- Sits between the producer blocks and the FIFO's data_input, push and full_out pins.

Parameters:
- WORDLENGHT, 8, width of each data word.
- N_REQ, 4, number of requesters (≥2).
- BURST_LEN, 4, maximum accepted words per grant (≥1).

Ports:
- clk  input  1  clock; the FIFO's clk_push domain.
- reset  input  1  asynchronous, active-high reset.
- synch_rst  input  1  synchronous clear; same effect as reset, applied on the clk edge.
- req  input  N_REQ  per-requester request; held high while the requester has words to send.
- data_in  input  N_REQ*WORDLENGHT  flattened producer data; requester i occupies bits [i*WORDLENGHT +: WORDLENGHT].
- fifo_full  input  1  from FIFO full_out.
- gnt  output  N_REQ  one-hot grant, registered.
- fifo_push  output  1  to FIFO push.
- fifo_data  output  WORDLENGHT  to FIFO data_input.
- owner  output  CeilLog2(N_REQ)  index of the granted requester, registered.
- busy  output  1  high while in BURST.

Behaviour:
- Reset (async or synch_rst):
  - state=IDLE, gnt=0, owner=0, busy=0.
  - beat counter=0.
  - rr pointer=N_REQ-1, so req[0] has first priority.
- FSM states: IDLE, BURST.
- IDLE:
  - If |req, pick the winner with rr_pick: first set req bit scanning from (ptr+1) mod N_REQ upward, wrapping.
  - Next cycle: state=BURST, gnt[winner]=1, owner=winner, ptr=winner, beat=0.
  - If no req, stay in IDLE.
- BURST:
  - fifo_push = req[owner] & ~fifo_full. This is combinational from registered gnt/owner, so the first push can occur in the first BURST cycle (one cycle after req is sampled in IDLE).
  - fifo_data = data_in slice for owner, combinational. It is driven even when fifo_push=0. In IDLE, fifo_data=0.
  - beat increments on each cycle with fifo_push=1. beat width is CeilLog2(BURST_LEN+1).
- Exit BURST to IDLE (gnt cleared next edge) when either:
  - fifo_push=1 and beat==BURST_LEN-1 (last beat accepted), or
  - req[owner]=0 (requester released; no push that cycle).
- Re-arbitration: IDLE is always visited for one cycle between bursts. Maximum throughput is BURST_LEN words per BURST_LEN+1 cycles.
- Backpressure: while fifo_full=1, BURST holds with no push and beat frozen. The grant is retained indefinitely; there is no timeout.
- Requester drops req while fifo_full=1: exit as above; no data lost, since no push occurred.
- Non-granted req changes during BURST: ignored until the next IDLE.
- Single requester continuously asserting: re-granted every time (pointer wraps to itself).
- Fairness: after owner k, priority order is k+1 … N_REQ-1, 0 … k.
- gnt is never multi-hot. fifo_push is never high unless gnt[owner]=1.
- Reset asserted mid-burst: fifo_push drops immediately (combinational from gnt=0). A partial burst is not resumed.

Optional Feature:
- Macro: FIFO_PUSH_ARBITER_STATS_EN.
- Defined:
  - Adds output push_count, width N_REQ*16: one 16-bit saturating counter per requester.
  - Counter i increments on each fifo_push while owner=i and holds at 16'hFFFF.
  - Cleared by reset and synch_rst.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST}.
  - CeilLog2 function.
  - STAT_W=16 constant.
- Sub-module rr_pick: purely combinational.
  - Inputs: req, ptr.
  - Outputs: found, idx.
  - Instantiated once.
- FSM, beat counter, data mux and stats counters stay in fifo_push_arbiter.

Test Plan:
- Reset, then req=4'b0001, fifo_full=0, data_in[0] stepping 0x10..0x17.
  - gnt=0001 one cycle after req is sampled.
  - fifo_push high 4 cycles; data 0x10,0x11,0x12,0x13 in order.
  - IDLE for one cycle, then re-grant to req0 with 0x14..0x17.
- req=4'b1111 held, fifo_full=0.
  - owner sequence 0,1,2,3,0.
  - Each burst is exactly 4 pushes; 5-cycle period per burst.
- Requester 2 granted; fifo_full=1 after the 2nd push for 6 cycles.
  - fifo_push=0 and gnt held for those 6 cycles, beat stays at 2.
  - After fifo_full drops, 2 more pushes, then IDLE.
- Requester 1 granted; req[1] drops after 1 push while req[3]=1.
  - BURST exits next edge; IDLE for one cycle.
  - Then gnt=1000, owner=3.
- Async reset pulse in the middle of the 3rd beat.
  - gnt=0 and fifo_push=0 immediately; ptr=3.
  - With req=4'b0110 after release, owner=1 is granted first.
- FIFO_PUSH_ARBITER_STATS_EN defined: force 70000 pushes from requester 0.
  - push_count[15:0]=16'hFFFF (saturated).
  - Other counters 0.
  - synch_rst clears all counters to 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned STAT_W = 16;

  // Bits needed to encode values 0..n-1; at least one bit.
  function automatic int unsigned CeilLog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = CeilLog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from farthest to nearest so the nearest candidate after ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      int unsigned c;
      c = (32'(ptr) + k) % N_REQ;
      if (req[IDX_W'(c)]) begin
        found = 1'b1;
        idx   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing the FIFO push port among N_REQ producers.
// Optional per-requester push counters enabled by FIFO_PUSH_ARBITER_STATS_EN.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned WORDLENGHT = 8,
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned BURST_LEN  = 4,
  localparam int unsigned OWN_W      = CeilLog2(N_REQ),
  localparam int unsigned BEAT_W     = CeilLog2(BURST_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        synch_rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WORDLENGHT-1:0] data_in,
  input  logic                        fifo_full,
  output logic [N_REQ-1:0]            gnt,
  output logic                        fifo_push,
  output logic [WORDLENGHT-1:0]       fifo_data,
  output logic [OWN_W-1:0]            owner,
  output logic                        busy
`ifdef FIFO_PUSH_ARBITER_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]     push_count
`endif
);

  arb_state_e        state;
  logic [OWN_W-1:0]  ptr;
  logic [BEAT_W-1:0] beat;
  logic              pick_found;
  logic [OWN_W-1:0]  pick_idx;
  logic              last_beat;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Push is qualified by the registered grant so a reset drops it at once.
  assign fifo_push = gnt[owner] & req[owner] & ~fifo_full;
  assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));

  always_comb begin
    fifo_data = '0;
    if (state == BURST) fifo_data = data_in[32'(owner)*WORDLENGHT +: WORDLENGHT];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      busy  <= 1'b0;
      beat  <= '0;
      ptr   <= OWN_W'(N_REQ - 1);
    end else if (synch_rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      busy  <= 1'b0;
      beat  <= '0;
      ptr   <= OWN_W'(N_REQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            state <= BURST;
            gnt   <= N_REQ'(1) << pick_idx;
            owner <= pick_idx;
            ptr   <= pick_idx;
            beat  <= '0;
            busy  <= 1'b1;
          end
        end
        BURST: begin
          // Full FIFO freezes everything; only release or the last beat ends a burst.
          if (fifo_push) begin
            if (last_beat) begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              beat  <= '0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end else if (!req[owner]) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            beat  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
  // Saturating count of accepted words per requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_count <= '0;
    end else if (synch_rst) begin
      push_count <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (fifo_push && (owner == OWN_W'(i)) && (push_count[i*STAT_W +: STAT_W] != '1)) begin
          push_count[i*STAT_W +: STAT_W] <= push_count[i*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
    end
  end
`endif

endmodule
